// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   state_t     : LSU FSM state (IDLE / REQ / WAIT)
//   F3_*        : funct3 size/sign encodings accepted by the LSU
//   f3_supported: funct3 is one of the five accepted encodings
//   f3_misaligned: access crosses its natural alignment (used only when
//                  LSU_MISALIGN_CHECK_EN is defined)
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_supported(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = (lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load lane select and extension.
//   word   in  32  raw memory word (word-aligned read data)
//   lane   in  2   byte address bits [1:0] of the load
//   funct3 in  3   size/sign code (B, H, W, BU, HU)
//   result out 32  selected lane, sign- or zero-extended to 32 bits
// Halfword selection looks at lane[1] only; word loads ignore lane.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    result = word;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between execute stage and a
// word-wide memory port.
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid, i_memread, i_memwrite, i_funct3, i_addr, i_wdata : op from execute
//   o_busy                upstream stall (combinational)
//   o_done, o_misaligned  single-cycle completion / fault pulses
//   o_rdata               extended load result, held until next load completes
//   o_mem_req/we/addr/wdata/be, i_mem_ready, i_mem_rvalid, i_mem_rdata : memory port
//   o_dbg_state           current FSM state for observation
// Memory handshake: a request is offered with o_mem_req=1 and its fields
// held stable until the cycle where i_mem_ready=1 (accepted on that edge);
// load data is taken on the first cycle in WAIT with i_mem_rvalid=1.
// Build option: define LSU_MISALIGN_CHECK_EN to fault misaligned H/W ops
// instead of issuing them (default: misalignment silently truncated).
module lsu
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_memread,
  input  logic        i_memwrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  state_t      state, state_next;
  logic        done_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic        done_q;
  logic        mis_q;
  logic [31:0] rdata_q;

  logic        op;
  logic        fault;
  logic        start;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_result;

  assign op = i_valid & (i_memread | i_memwrite);

`ifdef LSU_MISALIGN_CHECK_EN
  assign fault = (state == ST_IDLE) & op & f3_supported(i_funct3)
               & f3_misaligned(i_funct3, i_addr[1:0]);
`else
  assign fault = 1'b0;
`endif

  assign start = (state == ST_IDLE) & op & f3_supported(i_funct3) & ~fault;

  // Byte enables and lane placement of store data. Size comes from
  // funct3[1:0] so BU/HU codes shape the request like B/H.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << i_addr[1:0];
        lane_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = i_wdata;
      end
    endcase
  end

  // Next-state and completion logic.
  always_comb begin
    state_next = state;
    done_next  = fault;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_REQ;
      end
      ST_REQ: begin
        // i_mem_rvalid is deliberately ignored here.
        if (i_mem_ready) begin
          state_next = we_q ? ST_IDLE : ST_WAIT;
          done_next  = we_q;
        end
      end
      ST_WAIT: begin
        if (i_mem_rvalid) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= done_next;
      mis_q  <= fault;
      if (start) begin
        addr_q  <= i_addr;
        wdata_q <= lane_wdata;
        be_q    <= lane_be;
        we_q    <= i_memwrite;  // both read and write high -> store
        f3_q    <= i_funct3;
      end
      if ((state == ST_WAIT) && i_mem_rvalid) rdata_q <= load_result;
    end
  end

  lsu_load_align u_align (
    .word   (i_mem_rdata),
    .lane   (addr_q[1:0]),
    .funct3 (f3_q),
    .result (load_result)
  );

  assign o_mem_req    = (state == ST_REQ);
  assign o_mem_we     = o_mem_req & we_q;
  assign o_mem_be     = o_mem_req ? be_q : 4'b0000;
  assign o_mem_addr   = {addr_q[31:2], 2'b00};
  assign o_mem_wdata  = wdata_q;
  assign o_busy       = (state != ST_IDLE) | start | fault;
  assign o_done       = done_q;
  assign o_misaligned = mis_q;
  assign o_rdata      = rdata_q;
  assign o_dbg_state  = state;

endmodule
